// File: rtl/qfix_pkg.sv
// Shared constants and helpers for sign-magnitude fixed-point words.
// Bit N-1 is the sign, bits N-2:0 are the magnitude.
package qfix_pkg;

  localparam int QN_DEF = 32;
  localparam int QQ_DEF = 15;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic logic [QN_DEF-1:0] sm_word(
    input logic              s,
    input logic [QN_DEF-2:0] m
  );
    return {s, m};
  endfunction

endpackage

// File: rtl/qadd_rr_scheduler_sm_addsub.sv
// Combinational sign-magnitude add/subtract with magnitude saturation.
// Never produces negative zero.
module sm_addsub
  import qfix_pkg::*;
#(
  parameter int N = QN_DEF
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         op_i,
  output logic [N-1:0] y_o,
  output logic         ovf_o
);

  logic         sa;
  logic         sb;
  logic         sgn;
  logic [N-2:0] ma;
  logic [N-2:0] mb;
  logic [N-2:0] mag;
  logic [N-1:0] sum;

  // Add like signs (saturating) or subtract smaller magnitude from larger.
  always_comb begin
    sa    = a_i[N-1];
    sb    = b_i[N-1] ^ op_i;
    ma    = a_i[N-2:0];
    mb    = b_i[N-2:0];
    sum   = '0;
    mag   = '0;
    sgn   = 1'b0;
    ovf_o = 1'b0;
    if (sa == sb) begin
      sum = {1'b0, ma} + {1'b0, mb};
      if (sum[N-1]) begin
        mag   = '1;
        ovf_o = 1'b1;
      end else begin
        mag = sum[N-2:0];
      end
      sgn = sa;
    end else if (ma >= mb) begin
      mag = ma - mb;
      sgn = sa;
    end else begin
      mag = mb - ma;
      sgn = sb;
    end
    if (mag == '0) sgn = 1'b0;
    y_o = {sgn, mag};
  end

endmodule

// File: rtl/qadd_rr_scheduler.sv
// Round-robin shared sign-magnitude adder with one registered
// result slot and valid/ready handshake on both sides.
module qadd_rr_scheduler
  import qfix_pkg::*;
#(
  parameter int Q  = QQ_DEF,
  parameter int N  = QN_DEF,
  parameter int R  = 4,
  parameter int IW = $clog2(R)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [R-1:0]   req_valid,
  output logic [R-1:0]   req_ready,
  input  logic [R*N-1:0] req_a,
  input  logic [R*N-1:0] req_b,
  input  logic [R-1:0]   req_op,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [N-1:0]   res_data,
  output logic [IW-1:0]  res_id,
  output logic           res_ovf
);

  if (R < 2 || Q >= N) begin : g_param_chk
    $error("qadd_rr_scheduler: bad parameters");
  end

  logic          accept_en;
  logic          gnt_vld;
  logic [IW-1:0] gnt_id;
  logic [IW-1:0] idx;
  logic [IW:0]   sum_w;
  logic [IW-1:0] rr_q;
  logic [IW-1:0] rr_d;
  logic [N-1:0]  a_sel;
  logic [N-1:0]  b_sel;
  logic          op_sel;
  logic [N-1:0]  y;
  logic          ovf;

  logic          vld_q;
  logic [N-1:0]  data_q;
  logic [IW-1:0] id_q;
  logic          ovf_q;

  assign accept_en = !vld_q || res_ready;

  // Pick the first valid requester at or after rr_q, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    sum_w   = '0;
    idx     = '0;
    for (int k = 0; k < R; k++) begin
      sum_w = {1'b0, rr_q} + (IW+1)'(k);
      if (sum_w >= (IW+1)'(R)) sum_w = sum_w - (IW+1)'(R);
      idx = sum_w[IW-1:0];
      if (accept_en && !gnt_vld && req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  // One-hot accept to the winner and pointer advance past it.
  always_comb begin
    req_ready = '0;
    rr_d      = rr_q;
    if (gnt_vld) begin
      req_ready[gnt_id] = 1'b1;
      rr_d = (gnt_id == IW'(R-1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Route the winner's operands into the shared datapath.
  always_comb begin
    a_sel  = req_a[gnt_id*N +: N];
    b_sel  = req_b[gnt_id*N +: N];
    op_sel = req_op[gnt_id];
  end

  sm_addsub #(.N(N)) u_addsub (
    .a_i   (a_sel),
    .b_i   (b_sel),
    .op_i  (op_sel),
    .y_o   (y),
    .ovf_o (ovf)
  );

  // Output slot: load on grant, empty on drain, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      id_q   <= '0;
      ovf_q  <= 1'b0;
      rr_q   <= '0;
    end else begin
      rr_q <= rr_d;
      if (gnt_vld) begin
        vld_q  <= 1'b1;
        data_q <= y;
        id_q   <= gnt_id;
        ovf_q  <= ovf;
      end else if (res_ready) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign res_valid = vld_q;
  assign res_data  = data_q;
  assign res_id    = id_q;
  assign res_ovf   = ovf_q;

endmodule

// File: doc/qadd_rr_scheduler.md
Name: qadd_rr_scheduler

Overview:
- Shares one combinational sign-magnitude fixed-point add/subtract datapath among R requesters.
- Round-robin arbiter picks one valid request per cycle and computes a op b, where op is add or subtract.
- The result, the winning requester id and an overflow flag go into a single output register with valid/ready handshake.
- Sits between the fixed-point operand producers and downstream consumers; adds 1 cycle of latency and gives full throughput when the output is not stalled.

Parameters:
- Q, 15: fractional bits; informational only, the arithmetic is format-agnostic.
- N, 32: word width; bit N-1 is the sign, bits N-2:0 are the magnitude.
- R, 4: number of requesters; must be ≥2.
- IW, $clog2(R): width of the requester id.

Ports:
- clk  in  1  single clock; all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  R  per-requester request valid.
- req_ready  out  R  per-requester accept; at most one bit high per cycle (one-hot or zero).
- req_a  in  R*N  packed operand a; requester i occupies bits [i*N +: N].
- req_b  in  R*N  packed operand b; same packing.
- req_op  in  R  per-requester op: 0 = a+b, 1 = a-b.
- res_valid  out  1  output register holds a result.
- res_ready  in  1  downstream accepts the result.
- res_data  out  N  sign-magnitude result.
- res_id  out  IW  index of the requester that produced res_data.
- res_ovf  out  1  magnitude saturated.

Behaviour:
- Reset (async assert, sync release): res_valid=0, res_data=0, res_id=0, res_ovf=0, rr_ptr=0. req_ready is combinational and therefore 0 while res_valid=0 and req_valid=0.
- accept_en = !res_valid || res_ready. This allows back-to-back acceptance in the same cycle as a drain.
- Grant: when accept_en is high, grant = the first i with req_valid[i] set, searching from rr_ptr upward and wrapping modulo R. req_ready[grant]=1; all other req_ready bits are 0. If no request is valid, no grant.
- Pointer: on a grant, rr_ptr <= grant+1 (mod R). Otherwise rr_ptr holds.
- Handshake on the request side: a transfer occurs when req_valid[i] && req_ready[i]. Requesters must hold their operands until the transfer.
- Latency: the result is registered on the edge of acceptance. res_valid=1 on the next cycle, carrying res_data, res_id=grant and res_ovf.
- Output side: when res_valid && !res_ready, res_data, res_id and res_ovf stay stable and all req_ready bits are 0.
  - When res_valid && res_ready with no new grant, res_valid <= 0.
- Arithmetic (sub-module), on magnitudes ma and mb and signs sa and sb:
  - Effective sign of b: sb' = sb ^ op.
  - If sa == sb': sum = ma + mb, computed N bits wide. If the carry is set, magnitude = all ones and ovf=1; otherwise magnitude = sum. Sign = sa.
  - If sa != sb': if ma ≥ mb, magnitude = ma - mb and sign = sa; otherwise magnitude = mb - ma and sign = sb'. ovf=0.
  - Negative zero is never output: if magnitude == 0, sign = 0. Negative-zero inputs are accepted and behave as zero.
- Simultaneous events:
  - Drain and accept in the same cycle: the new result replaces the old one and res_valid stays 1.
  - A request that deasserts before it is granted is simply skipped.
- Reset mid-operation clears any pending result; it is lost and not replayed.
- No internal FIFO. Output occupancy is 0 or 1. The arbiter is the only state besides the output register.

Decomposition:
- Package qfix_pkg:
  - localparam defaults for N and Q.
  - OP_ADD=1'b0 and OP_SUB=1'b1 constants.
  - A function that builds sign-magnitude words from sign and magnitude, for use by the TB.
- Sub-module sm_addsub (purely combinational):
  - Inputs a[N], b[N], op. Outputs y[N], ovf.
  - Implements the arithmetic rules above and is reused in the TB reference model.
- The top level holds the rr arbiter, the operand mux and the output register.

Test Plan:
- Add: R0 sends a=0x0000C000 (1.5), b=0x00002000 (0.25), op=0, res_ready=1 → next cycle res_valid=1, res_data=0x0000E000, res_id=0, res_ovf=0.
- Sub / sign cases:
  - a=0x00002000, b=0x0000C000, op=1 → res_data=0x8000A000 (-1.25).
  - a=0x0000C000, b=0x8000C000, op=0 → 0x00000000 (no -0).
  - a=0x80000000, b=0x00000000, op=1 → 0x00000000.
- Overflow: a=0x7FFFFFFF, b=0x00000001, op=0 → res_data=0x7FFFFFFF, res_ovf=1. The same operands with op=1 → 0x7FFFFFFE, res_ovf=0.
- Fairness: all 4 requesters hold valid continuously, res_ready=1 → res_id sequence 0,1,2,3,0,1 on consecutive cycles, one req_ready per cycle. Then drop R1 → sequence 2,3,0,2,3,0.
- Backpressure: hold res_ready=0 for 5 cycles with all valids high → res_valid=1, outputs frozen, req_ready=0 throughout. Release → the next grant issues in the same cycle the result drains, with no bubble.
- Reset: assert rst_n=0 asynchronously while res_valid=1 → res_valid, res_data, res_id and res_ovf go to 0 immediately. After release, the first grant goes to R0 when all are valid.
